// File: rtl/if_scratch_writer.sv
// IF map loader: accepts a word stream, writes it into a circular IF scratchpad and
// exposes the write pointer/parity so the consumer side can detect full and empty.
module if_scratch_writer #(
    parameter int unsigned IF_CELL_SIZE    = 8,
    parameter int unsigned IF_ADDRESS_SIZE = 8,
    parameter int unsigned CELL_NUMS_IF    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [IF_CELL_SIZE-1:0]    in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic [IF_ADDRESS_SIZE:0]   free_addr,
    input  logic                       free_wrap,
    output logic                       scratch_wen,
    output logic [IF_ADDRESS_SIZE:0]   scratch_waddr,
    output logic [IF_CELL_SIZE-1:0]    scratch_wdata,
    output logic [IF_ADDRESS_SIZE:0]   write_addr_if,
    output logic                       write_cnt_if,
    output logic                       full,
    output logic                       busy,
    output logic                       load_done
);

    localparam int unsigned AddrW = IF_ADDRESS_SIZE + 1;
    localparam logic [AddrW-1:0] LastAddr = AddrW'(CELL_NUMS_IF - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                  state_q, state_d;
    logic [AddrW-1:0]        write_addr_q, write_addr_d;
    logic                    write_cnt_q, write_cnt_d;
    logic                    wen_q, wen_d;
    logic [AddrW-1:0]        waddr_q, waddr_d;
    logic [IF_CELL_SIZE-1:0] wdata_q, wdata_d;

    logic full_raw;
    logic accept;

    // Same address with opposite parity means the writer has lapped the consumer.
    assign full_raw = (write_addr_q == free_addr) && (write_cnt_q != free_wrap);
    assign full     = rst && full_raw;
    assign in_ready = (state_q == StRun) && !full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        write_addr_d = write_addr_q;
        write_cnt_d  = write_cnt_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        if (start) begin
            // Restart wins over any accept presented in the same cycle.
            state_d      = StRun;
            write_addr_d = '0;
            write_cnt_d  = 1'b0;
        end else begin
            if (accept) begin
                wen_d   = 1'b1;
                waddr_d = write_addr_q;
                wdata_d = in_data;
                if (write_addr_q == LastAddr) begin
                    write_addr_d = '0;
                    write_cnt_d  = ~write_cnt_q;
                end else begin
                    write_addr_d = write_addr_q + AddrW'(1);
                end
            end

            unique case (state_q)
                StIdle:  state_d = StIdle;
                StRun:   if (accept && in_last) state_d = StFlush;
                StFlush: state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            write_addr_q <= '0;
            write_cnt_q  <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            write_addr_q <= write_addr_d;
            write_cnt_q  <= write_cnt_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign scratch_wen   = wen_q;
    assign scratch_waddr = waddr_q;
    assign scratch_wdata = wdata_q;
    assign write_addr_if = write_addr_q;
    assign write_cnt_if  = write_cnt_q;
    assign busy          = (state_q != StIdle);
    assign load_done     = (state_q == StDone);

endmodule

// File: tb/tb_if_scratch_writer.sv
// Directed bench for if_scratch_writer at CELL_NUMS_IF=8: load, full, same-cycle free,
// wrap, restart and asynchronous reset.
module tb_if_scratch_writer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [8:0] free_addr;
    logic       free_wrap;
    logic       scratch_wen;
    logic [8:0] scratch_waddr;
    logic [7:0] scratch_wdata;
    logic [8:0] write_addr_if;
    logic       write_cnt_if;
    logic       full;
    logic       busy;
    logic       load_done;

    int tests;
    int failed;

    if_scratch_writer #(
        .IF_CELL_SIZE   (8),
        .IF_ADDRESS_SIZE(8),
        .CELL_NUMS_IF   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .free_addr    (free_addr),
        .free_wrap    (free_wrap),
        .scratch_wen  (scratch_wen),
        .scratch_waddr(scratch_waddr),
        .scratch_wdata(scratch_wdata),
        .write_addr_if(write_addr_if),
        .write_cnt_if (write_cnt_if),
        .full         (full),
        .busy         (busy),
        .load_done    (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wen"}, {31'd0, scratch_wen}, 32'd0);
        chk({tag, "_waddr"}, {23'd0, scratch_waddr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, scratch_wdata}, 32'd0);
        chk({tag, "_waif"}, {23'd0, write_addr_if}, 32'd0);
        chk({tag, "_wcnt"}, {31'd0, write_cnt_if}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        free_addr = 9'd0;
        free_wrap = 1'b1;
        #2;
        // Reset: everything low even with free_wrap set (raw full condition true).
        chk_zero_outputs("reset");
        free_wrap = 1'b0;
        #6 rst = 1'b1;
        tick();

        // in_valid is ignored in IDLE.
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        chk("idle_ignore_wen", {31'd0, scratch_wen}, 32'd0);
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        // Basic load 0x11..0x15.
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        in_last = 1'b1;   // without in_valid this must be inert
        tick();
        in_last = 1'b0;
        chk("last_no_valid_busy", {31'd0, busy}, 32'd1);
        chk("last_no_valid_rdy", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            send(8'h11 + 8'(i), i == 4);
            chk($sformatf("basic_wen%0d", i), {31'd0, scratch_wen}, 32'd1);
            chk($sformatf("basic_waddr%0d", i), {23'd0, scratch_waddr}, i);
            chk($sformatf("basic_wdata%0d", i), {24'd0, scratch_wdata}, 32'h11 + i);
        end
        chk("flush_rdy", {31'd0, in_ready}, 32'd0);
        chk("flush_done", {31'd0, load_done}, 32'd0);
        in_valid = 1'b1;   // offered in FLUSH, must not be taken
        tick();
        in_valid = 1'b0;
        chk("done_pulse", {31'd0, load_done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_wen", {31'd0, scratch_wen}, 32'd0);
        chk("done_hold_waddr", {23'd0, scratch_waddr}, 32'd4);
        chk("done_hold_wdata", {24'd0, scratch_wdata}, 32'h15);
        tick();
        chk("idle_done", {31'd0, load_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("basic_waif", {23'd0, write_addr_if}, 32'd5);
        chk("basic_wcnt", {31'd0, write_cnt_if}, 32'd0);

        // Full: consumer parked at 0/0, eight words fill the ring.
        pulse_start();
        chk("full_restart_waif", {23'd0, write_addr_if}, 32'd0);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        chk("full_waif", {23'd0, write_addr_if}, 32'd0);
        chk("full_wcnt", {31'd0, write_cnt_if}, 32'd1);
        send(8'h99, 1'b0);
        chk("full_blocked_wen", {31'd0, scratch_wen}, 32'd0);
        chk("full_blocked_waif", {23'd0, write_addr_if}, 32'd0);

        // Same-cycle free: accept is allowed as the consumer releases slot 0.
        free_addr = 9'd1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        #1;
        chk("samefree_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("samefree_wen", {31'd0, scratch_wen}, 32'd1);
        chk("samefree_waddr", {23'd0, scratch_waddr}, 32'd0);
        chk("samefree_wdata", {24'd0, scratch_wdata}, 32'hA5);
        chk("samefree_waif", {23'd0, write_addr_if}, 32'd1);
        chk("samefree_full", {31'd0, full}, 32'd1);

        // Wrap: consumer keeps pace, so the ring never fills; 10 words.
        free_addr = 9'd0;
        free_wrap = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send(8'h40 + 8'(i), i == 9);
            chk($sformatf("wrap_waddr%0d", i), {23'd0, scratch_waddr}, i % 8);
            chk($sformatf("wrap_wen%0d", i), {31'd0, scratch_wen}, 32'd1);
            free_addr = 9'((i + 1) % 8);
            free_wrap = (i + 1) >= 8;
        end
        chk("wrap_waif", {23'd0, write_addr_if}, 32'd2);
        chk("wrap_wcnt", {31'd0, write_cnt_if}, 32'd1);
        tick();
        chk("wrap_done", {31'd0, load_done}, 32'd1);
        tick();

        // Restart on the cycle of the third accept.
        free_addr = 9'd0;
        free_wrap = 1'b0;
        pulse_start();
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h53;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_wen", {31'd0, scratch_wen}, 32'd0);
        chk("restart_waif", {23'd0, write_addr_if}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_rdy", {31'd0, in_ready}, 32'd1);
        chk("restart_hold_waddr", {23'd0, scratch_waddr}, 32'd1);
        chk("restart_hold_wdata", {24'd0, scratch_wdata}, 32'h52);

        // Asynchronous reset between edges, with a write pending on scratch_wen.
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        chk("pre_rst_wen", {31'd0, scratch_wen}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        #3 rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h70;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_wen%0d", i), {31'd0, scratch_wen}, 32'd0);
            chk($sformatf("post_rst_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        pulse_start();
        send(8'h71, 1'b1);
        chk("post_rst_load_wen", {31'd0, scratch_wen}, 32'd1);
        chk("post_rst_load_waddr", {23'd0, scratch_waddr}, 32'd0);
        chk("post_rst_load_wdata", {24'd0, scratch_wdata}, 32'h71);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_scratch_writer.md
IF_SCRATCH_WRITER -- requirements
Module: if_scratch_writer

Parameters
REQ-001 SHALL have IF_CELL_SIZE, default 8, the IF data word width in bits.
REQ-002 SHALL have IF_ADDRESS_SIZE, default 8; address and pointer ports are [IF_ADDRESS_SIZE:0].
REQ-003 SHALL have CELL_NUMS_IF, default 8, the IF scratchpad depth in entries; legal range 2 to 2^(IF_ADDRESS_SIZE+1).

Interface
REQ-004 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1, the reset; asynchronous and active-low.
REQ-006 SHALL have start, input, 1: a one-cycle pulse that begins a new IF map load.
REQ-007 SHALL have in_valid, input, 1, and in_data, input, IF_CELL_SIZE: the upstream word stream.
REQ-008 SHALL have in_last, input, 1, qualified by in_valid: marks the final word of the IF map.
REQ-009 SHALL have in_ready, output, 1: the block accepts a word in any cycle where in_valid and in_ready are both high.
REQ-010 SHALL have free_addr, input, IF_ADDRESS_SIZE+1, and free_wrap, input, 1: the consumer's oldest live entry (its start_if) and that pointer's wrap parity.
REQ-011 SHALL have scratch_wen, output, 1; scratch_waddr, output, IF_ADDRESS_SIZE+1; and scratch_wdata, output, IF_CELL_SIZE: the IF scratchpad write port.
REQ-012 SHALL have write_addr_if, output, IF_ADDRESS_SIZE+1, and write_cnt_if, output, 1: the next write slot and its wrap parity, both consumed by the checker.
REQ-013 SHALL have full, output, 1; busy, output, 1; and load_done, output, 1.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, FLUSH and DONE.
REQ-015 SHALL make the IDLE->RUN transition on start, clearing write_addr_if and write_cnt_if to 0 in the same edge.
REQ-016 SHALL drive in_ready as (state==RUN) && !full, combinationally from the current pointers and the free_* inputs.
REQ-017 SHALL assert full when write_addr_if==free_addr && write_cnt_if!=free_wrap; the slot is empty when both are equal and the parities match.
REQ-018 SHALL, on each accept, register in_data into scratch_wdata and write_addr_if into scratch_waddr, and assert scratch_wen in the next cycle only (1-cycle latency).
REQ-019 SHALL, on each accept, increment write_addr_if.
REQ-020 SHALL, when write_addr_if==CELL_NUMS_IF-1 at an accept, wrap write_addr_if to 0 and toggle write_cnt_if.
REQ-021 SHALL move RUN->FLUSH on an accept with in_last=1, FLUSH->DONE after one cycle (the final write is issued), and DONE->IDLE after one cycle.
REQ-022 SHALL assert load_done for exactly the one cycle spent in DONE.
REQ-023 SHALL assert busy in RUN, FLUSH and DONE.
REQ-024 SHALL keep in_ready low in FLUSH, DONE and IDLE.
REQ-025 SHALL, when start arrives in RUN, FLUSH or DONE, restart: clear both pointers, drop any pending accept (no write next cycle) and enter RUN; start has priority over an accept in the same cycle.
REQ-026 SHALL evaluate full from the same-cycle free_addr/free_wrap when the consumer frees an entry in the same cycle as a full condition, so an accept is allowed in that cycle.
REQ-027 SHALL ignore in_valid outside RUN; in_last without in_valid SHALL have no effect.
REQ-028 SHALL leave scratch_waddr and scratch_wdata holding their last values when scratch_wen is low.

Reset
REQ-029 SHALL, while rst is low, immediately force state IDLE and drive all outputs to 0 (write_addr_if, write_cnt_if, scratch_*, full, busy, load_done); in_ready is 0 because the FSM is in IDLE.
REQ-030 SHALL, on rst asserted mid-load, discard any pending write (scratch_wen=0) and require a fresh start after release.

Verification (CELL_NUMS_IF=8)
REQ-031 SHALL cover basic load: start, then 5 words 0x11..0x15 with last on 0x15 -> writes to addresses 0..4, one cycle after each accept; load_done pulses 2 cycles after the last accept; write_addr_if=5, write_cnt_if=0.
REQ-032 SHALL cover full: free_addr=0, free_wrap=0, 8 words streamed -> full=1, in_ready=0 after the 8th accept, write_addr_if=0, write_cnt_if=1.
REQ-033 SHALL cover same-cycle free: while full, raise free_addr to 1 together with in_valid -> the accept occurs that cycle and the word is written to address 0.
REQ-034 SHALL cover wrap: free pointer tracks writes; 10 words -> addresses 0..7 then 0,1; write_cnt_if toggles once.
REQ-035 SHALL cover restart: start asserted on the cycle of the 3rd accept -> no write for that word, write_addr_if=0, state RUN.
REQ-036 SHALL cover async reset: rst low between clock edges mid-load -> all outputs 0 without waiting for a clock edge; no scratch_wen after release until a new start plus an accept.
